fifo_32x24: RTL and testbench

- Synchronous first-in first-out buffer: 32 entries of 24 bits, one clock domain.
- Exposes FULL/EMPTY flags, raw read/write pointers and an occupancy count (used_words), so upstream and downstream logic and debug can observe its state.
- Sits between a single producer and a single consumer that share one clock.

---
 rtl/fifo_32x24.sv | 66 ++++++
 tb/tb_fifo_32x24.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/fifo_32x24.sv
// Single-clock 32x24 FIFO with registered read data, exposing raw pointers,
// occupancy and full/empty flags for upstream/downstream control and debug.
module fifo_32x24 #(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clock,
    input  logic                  async_reset_n,
    input  logic                  read_enable,
    input  logic                  write_enable,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  FULL,
    output logic                  EMPTY,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [ADDR_WIDTH:0]   read_pointer,
    output logic [ADDR_WIDTH:0]   write_pointer,
    output logic [ADDR_WIDTH:0]   used_words
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  wr_acc;
    logic                  rd_acc;

    // Flags decode the wrap bit: equal addresses mean empty when the wrap
    // bits agree and full when they differ, so the two can never coincide.
    assign EMPTY      = (wr_ptr == rd_ptr);
    assign FULL       = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                        (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);
    assign used_words = wr_ptr - rd_ptr;

    assign wr_acc = write_enable && !FULL && async_reset_n;
    assign rd_acc = read_enable && !EMPTY && async_reset_n;

    always_ff @(posedge clock or negedge async_reset_n) begin
        if (!async_reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            dout_q <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                dout_q <= mem[rd_ptr[ADDR_WIDTH-1:0]];
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage is left uninitialised; the pointers alone define valid contents.
    always_ff @(posedge clock) begin
        if (wr_acc) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= data_in;
        end
    end

    assign data_out      = dout_q;
    assign read_pointer  = rd_ptr;
    assign write_pointer = wr_ptr;

endmodule

// File: tb/tb_fifo_32x24.sv
// Randomized scoreboard bench for fifo_32x24 against a queue-based reference.
module tb_fifo_32x24;

    logic        clock = 1'b0;
    logic        async_reset_n;
    logic        read_enable;
    logic        write_enable;
    logic [23:0] data_in;
    logic        FULL;
    logic        EMPTY;
    logic [23:0] data_out;
    logic [5:0]  read_pointer;
    logic [5:0]  write_pointer;
    logic [5:0]  used_words;

    int checks = 0;
    int errors = 0;

    logic [23:0] model_q[$];
    logic [23:0] exp_q[$];
    int          m_rp = 0;
    int          m_wp = 0;
    logic [23:0] m_dout = '0;
    logic [5:0]  last_rp = '0;

    always #5 clock = ~clock;

    fifo_32x24 dut (
        .clock         (clock),
        .async_reset_n (async_reset_n),
        .read_enable   (read_enable),
        .write_enable  (write_enable),
        .data_in       (data_in),
        .FULL          (FULL),
        .EMPTY         (EMPTY),
        .data_out      (data_out),
        .read_pointer  (read_pointer),
        .write_pointer (write_pointer),
        .used_words    (used_words)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; acceptance is decided from the model occupancy before the edge.
    task automatic cycle(input bit we, input bit re, input logic [23:0] d);
        bit wacc;
        bit racc;
        write_enable = we;
        read_enable  = re;
        data_in      = d;
        wacc = we && (model_q.size() < 32);
        racc = re && (model_q.size() != 0);
        @(posedge clock);
        if (racc) begin
            m_dout = model_q.pop_front();
            exp_q.push_back(m_dout);
            m_rp = (m_rp + 1) % 64;
        end
        if (wacc) begin
            model_q.push_back(d);
            m_wp = (m_wp + 1) % 64;
        end
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_read_pointer"}, read_pointer, 0);
        chk({tag, "_write_pointer"}, write_pointer, 0);
        chk({tag, "_used_words"}, used_words, 0);
        chk({tag, "_data_out"}, data_out, 0);
        chk({tag, "_EMPTY"}, EMPTY, 1);
        chk({tag, "_FULL"}, FULL, 0);
    endtask

    task automatic mid_reset();
        @(negedge clock);
        #2;
        async_reset_n = 1'b0;
        #1;
        check_reset_outputs("midrst_immediate");
        chk("midrst_pending_reads", exp_q.size(), 0);
        model_q.delete();
        exp_q.delete();
        m_rp   = 0;
        m_wp   = 0;
        m_dout = '0;
        write_enable = 1'b1;
        read_enable  = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check_reset_outputs("midrst_held");
        @(negedge clock);
        #2;
        async_reset_n = 1'b1;
    endtask

    // Monitor: compares state every cycle and pops the scoreboard whenever a read retires.
    always @(negedge clock) begin
        if (async_reset_n) begin
            chk("read_pointer", read_pointer, m_rp);
            chk("write_pointer", write_pointer, m_wp);
            chk("used_words", used_words, model_q.size());
            chk("FULL", FULL, model_q.size() == 32);
            chk("EMPTY", EMPTY, model_q.size() == 0);
            chk("data_out_hold", data_out, m_dout);
            if (read_pointer != last_rp) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_read: data_out %0h with no expected word at %0t", data_out, $time);
                end else begin
                    chk("read_data", data_out, exp_q.pop_front());
                end
            end
        end
        last_rp = read_pointer;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        async_reset_n = 1'b0;
        write_enable  = 1'b1;
        read_enable   = 1'b1;
        data_in       = 24'hABCDEF;
        repeat (3) @(posedge clock);
        #1;
        check_reset_outputs("reset");
        @(negedge clock);
        #2;
        async_reset_n = 1'b1;

        // Fill, then one write beyond full.
        repeat (33) cycle(1'b1, 1'b0, 24'($urandom));
        // Drain, then reads beyond empty.
        repeat (35) cycle(1'b0, 1'b1, 24'($urandom));
        // Both enables from empty, then steady state.
        repeat (10) cycle(1'b1, 1'b1, 24'($urandom));
        // Fill to full, then both enables at full.
        repeat (31) cycle(1'b1, 1'b0, 24'($urandom));
        repeat (3) cycle(1'b1, 1'b1, 24'($urandom));
        repeat (40) cycle(1'b0, 1'b1, 24'($urandom));

        // Random interleaving with write bias, then read bias, to wrap pointers.
        repeat (200) cycle($urandom_range(0, 99) < 65, $urandom_range(0, 99) < 45, 24'($urandom));
        repeat (200) cycle($urandom_range(0, 99) < 45, $urandom_range(0, 99) < 65, 24'($urandom));

        mid_reset();

        repeat (150) cycle($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50, 24'($urandom));
        repeat (40) cycle(1'b0, 1'b1, 24'($urandom));
        @(negedge clock);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        chk("model_drained", model_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
